// File: rtl/whack_pkg.sv
// Shared encodings for the whack-a-mole game blocks.
// State codes are the values driven on the state output.
package whack_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_UP   = 2'd2,
        ST_END  = 2'd3
    } state_e;

    localparam int LFSR_W  = 16;
    // Taps 16,14,13,11 in right-shift form: bits 0,2,3,5 feed bit 15
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;
    localparam int TIMER_W = 16;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, shifting right with feedback into the MSB.
// Free-running entropy source shared by the game blocks.
module lfsr16
    import whack_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q, q_d;
    logic              fb;

    assign fb  = ^(q_q & LFSR_TAPS);
    assign q_d = en ? {fb, q_q[LFSR_W-1:1]} : q_q;
    assign q   = q_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) q_q <= SEED;
        else        q_q <= q_d;
    end

endmodule

// File: rtl/whack_a_mole_multi.sv
// N-hole whack-a-mole controller: random mole/delay from an LFSR,
// shrinking hit window, lives, and a blinking game-over display.
module whack_a_mole_multi
    import whack_pkg::*;
#(
    parameter int          N_MOLES     = 4,
    parameter int          TICK_DIV    = 100000,
    parameter int          WAIT_MIN    = 500,
    parameter int          WAIT_SPAN   = 1024,
    parameter int          HIT_INIT    = 1000,
    parameter int          HIT_MIN     = 300,
    parameter int          HIT_STEP    = 50,
    parameter int          STEP_EVERY  = 4,
    parameter int          LIVES_INIT  = 3,
    parameter int          SCORE_W     = 8,
    parameter int          LIVES_W     = 4,
    parameter int          BLINK_TICKS = 250,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_MOLES-1:0] buttons,
    output logic [N_MOLES-1:0] mole,
    output logic [SCORE_W-1:0] score,
    output logic [LIVES_W-1:0] lives,
    output logic [1:0]         state,
    output logic               hit_pulse,
    output logic               miss_pulse
);

    localparam int TCW = $clog2(TICK_DIV + 1);
    localparam int HCW = $clog2(STEP_EVERY + 1);
    localparam int IW  = $clog2(N_MOLES);

    localparam logic [TIMER_W-1:0] T_WMIN  = TIMER_W'(WAIT_MIN);
    localparam logic [TIMER_W-1:0] T_HINIT = TIMER_W'(HIT_INIT);
    localparam logic [TIMER_W-1:0] T_HMIN  = TIMER_W'(HIT_MIN);
    localparam logic [TIMER_W-1:0] T_HSTEP = TIMER_W'(HIT_STEP);
    localparam logic [TIMER_W-1:0] T_FLOOR = TIMER_W'(HIT_MIN + HIT_STEP);
    localparam logic [TIMER_W-1:0] T_BLINK = TIMER_W'(BLINK_TICKS);
    localparam logic [TIMER_W-1:0] T_ONE   = TIMER_W'(1);
    localparam logic [LFSR_W-1:0]  SPAN_MK = LFSR_W'(WAIT_SPAN - 1);
    localparam logic [7:0]         NM8     = 8'(N_MOLES);
    localparam logic [TCW-1:0]     TC_LAST = TCW'(TICK_DIV - 1);
    localparam logic [HCW-1:0]     HC_STEP = HCW'(STEP_EVERY);
    localparam logic [LIVES_W-1:0] L_INIT  = LIVES_W'(LIVES_INIT);
    localparam logic [LIVES_W-1:0] L_ONE   = LIVES_W'(1);
    localparam logic [N_MOLES-1:0] M_ONE   = N_MOLES'(1);

    state_e             st_q, st_d;
    logic [N_MOLES-1:0] mole_q, mole_d, btn_prev_q;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic               hit_q, hit_d, miss_q, miss_d;
    logic [TCW-1:0]     tcnt_q, tcnt_d;
    logic [TIMER_W-1:0] tmr_q, tmr_d, win_q, win_d;
    logic [HCW-1:0]     hcnt_q, hcnt_d;
    logic [IW-1:0]      sel_q, sel_d;

    logic [LFSR_W-1:0]  lfsr;
    logic [N_MOLES-1:0] press, sel_mask;
    logic [TIMER_W-1:0] delay;
    logic [IW-1:0]      idx;
    logic [HCW-1:0]     hcnt_inc;
    logic               tick, wrong, right;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .q     (lfsr)
    );

    assign press    = buttons & ~btn_prev_q;
    assign tick     = (st_q != ST_IDLE) && (tcnt_q == TC_LAST);
    assign delay    = T_WMIN + (lfsr & SPAN_MK);
    assign idx      = IW'(lfsr[7:0] % NM8);
    assign sel_mask = M_ONE << sel_q;
    assign wrong    = |(press & ~sel_mask);
    assign right    = |(press & sel_mask);
    assign hcnt_inc = hcnt_q + HCW'(1);

    always_comb begin
        st_d    = st_q;
        mole_d  = mole_q;
        score_d = score_q;
        lives_d = lives_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        tcnt_d  = tcnt_q;
        tmr_d   = tmr_q;
        win_d   = win_q;
        hcnt_d  = hcnt_q;
        sel_d   = sel_q;
        if (st_q != ST_IDLE) tcnt_d = tick ? '0 : tcnt_q + TCW'(1);
        if (tick && tmr_q != '0) tmr_d = tmr_q - T_ONE;
        unique case (st_q)
            ST_IDLE: begin
                if (|press) begin
                    st_d    = ST_WAIT;
                    score_d = '0;
                    lives_d = L_INIT;
                    win_d   = T_HINIT;
                    hcnt_d  = '0;
                    tmr_d   = delay;
                    tcnt_d  = '0;
                end
            end
            ST_WAIT: begin
                if (tick && tmr_q == T_ONE) begin
                    st_d   = ST_UP;
                    sel_d  = idx;
                    mole_d = M_ONE << idx;
                    tmr_d  = win_q;
                end
            end
            ST_UP: begin
                // A wrong button outranks a simultaneous correct one
                if (wrong || (!right && tick && tmr_q == T_ONE)) begin
                    miss_d = 1'b1;
                    mole_d = '0;
                    if (lives_q <= L_ONE) begin
                        lives_d = '0;
                        st_d    = ST_END;
                        mole_d  = '1;
                        tmr_d   = T_BLINK;
                    end else begin
                        lives_d = lives_q - L_ONE;
                        st_d    = ST_WAIT;
                        tmr_d   = delay;
                    end
                end else if (right) begin
                    hit_d  = 1'b1;
                    mole_d = '0;
                    st_d   = ST_WAIT;
                    tmr_d  = delay;
                    hcnt_d = hcnt_inc;
                    if (score_q != '1) score_d = score_q + SCORE_W'(1);
                    if (hcnt_inc == HC_STEP) begin
                        hcnt_d = '0;
                        win_d  = (win_q >= T_FLOOR) ? win_q - T_HSTEP : T_HMIN;
                    end
                end
            end
            ST_END: begin
                if (|press) begin
                    st_d   = ST_IDLE;
                    mole_d = '0;
                end else if (tick && tmr_q == T_ONE) begin
                    mole_d = ~mole_q;
                    tmr_d  = T_BLINK;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q       <= ST_IDLE;
            mole_q     <= '0;
            score_q    <= '0;
            lives_q    <= L_INIT;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            btn_prev_q <= '0;
            tcnt_q     <= '0;
            tmr_q      <= '0;
            win_q      <= T_HINIT;
            hcnt_q     <= '0;
            sel_q      <= '0;
        end else begin
            st_q       <= st_d;
            mole_q     <= mole_d;
            score_q    <= score_d;
            lives_q    <= lives_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            btn_prev_q <= buttons;
            tcnt_q     <= tcnt_d;
            tmr_q      <= tmr_d;
            win_q      <= win_d;
            hcnt_q     <= hcnt_d;
            sel_q      <= sel_d;
        end
    end

    assign mole       = mole_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign state      = st_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;

endmodule

// File: tb/tb_whack_a_mole_multi.sv
// Bench for whack_a_mole_multi: absolute-tick game model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_whack_a_mole_multi;

    localparam int N     = 4;
    localparam int TD    = 4;
    localparam int WMIN  = 2;
    localparam int WSPAN = 4;
    localparam int HINIT = 8;
    localparam int HMIN  = 4;
    localparam int HSTEP = 2;
    localparam int SEV   = 2;
    localparam int LINIT = 3;
    localparam int SW    = 2;
    localparam int LW    = 4;
    localparam int BLINK = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [N-1:0]  buttons = '0;
    logic [N-1:0]  mole;
    logic [SW-1:0] score;
    logic [LW-1:0] lives;
    logic [1:0]    state;
    logic          hit_pulse, miss_pulse;

    whack_a_mole_multi #(
        .N_MOLES(N), .TICK_DIV(TD), .WAIT_MIN(WMIN), .WAIT_SPAN(WSPAN),
        .HIT_INIT(HINIT), .HIT_MIN(HMIN), .HIT_STEP(HSTEP),
        .STEP_EVERY(SEV), .LIVES_INIT(LINIT), .SCORE_W(SW),
        .LIVES_W(LW), .BLINK_TICKS(BLINK), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(rst_n), .buttons(buttons), .mole(mole),
        .score(score), .lives(lives), .state(state),
        .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Model: game time measured in absolute tick numbers, events fire
    // when the running tick count reaches a stored target.
    int m_st, m_mole, m_score, m_lives, m_hit, m_miss, m_win, m_hsc;
    int m_cyc, m_ticks, m_target, m_sel, m_prev, m_lfsr;

    task automatic m_reset();
        m_st = 0; m_mole = 0; m_score = 0; m_lives = LINIT;
        m_hit = 0; m_miss = 0; m_win = HINIT; m_hsc = 0;
        m_cyc = 0; m_ticks = 0; m_target = 0; m_sel = 0;
        m_prev = 0; m_lfsr = 'hACE1;
    endtask

    task automatic m_lose(input int delay);
        m_miss = 1;
        m_mole = 0;
        if (m_lives == 1) begin
            m_lives = 0; m_st = 3; m_mole = (1 << N) - 1;
            m_target = m_ticks + BLINK;
        end else begin
            m_lives = m_lives - 1; m_st = 1;
            m_target = m_ticks + delay;
        end
    endtask

    task automatic m_step();
        int b, press, draw, delay, idx, tick, selm, fb;
        b = int'(buttons);
        press = b & ~m_prev;
        draw = m_lfsr;
        delay = WMIN + (draw % WSPAN);
        idx = (draw % 256) % N;
        tick = (m_st != 0 && (m_cyc % TD) == TD - 1) ? 1 : 0;
        if (m_st != 0) m_cyc++;
        if (tick != 0) m_ticks++;
        m_hit = 0;
        m_miss = 0;
        selm = 1 << m_sel;
        case (m_st)
            0: if (press != 0) begin
                m_st = 1; m_score = 0; m_lives = LINIT; m_win = HINIT;
                m_hsc = 0; m_cyc = 0; m_ticks = 0; m_target = delay;
            end
            1: if (tick != 0 && m_ticks == m_target) begin
                m_st = 2; m_sel = idx; m_mole = 1 << idx;
                m_target = m_ticks + m_win;
            end
            2: begin
                if ((press & ~selm) != 0) m_lose(delay);
                else if ((press & selm) != 0) begin
                    m_hit = 1; m_mole = 0; m_st = 1;
                    m_target = m_ticks + delay;
                    if (m_score < (1 << SW) - 1) m_score++;
                    m_hsc++;
                    if (m_hsc == SEV) begin
                        m_hsc = 0;
                        m_win = (m_win - HSTEP < HMIN) ? HMIN : m_win - HSTEP;
                    end
                end else if (tick != 0 && m_ticks == m_target) m_lose(delay);
            end
            default: if (press != 0) begin
                m_st = 0; m_mole = 0;
            end else if (tick != 0 && m_ticks == m_target) begin
                m_mole = m_mole ^ ((1 << N) - 1);
                m_target = m_ticks + BLINK;
            end
        endcase
        m_prev = b;
        fb = (m_lfsr ^ (m_lfsr >> 2) ^ (m_lfsr >> 3) ^ (m_lfsr >> 5)) & 1;
        m_lfsr = ((m_lfsr >> 1) | (fb << 15)) & 'hFFFF;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
    end

    always @(negedge clk) begin
        chk("mole", 32'(mole), 32'(m_mole));
        chk("score", 32'(score), 32'(m_score));
        chk("lives", 32'(lives), 32'(m_lives));
        chk("state", 32'(state), 32'(m_st));
        chk("hit_pulse", 32'(hit_pulse), 32'(m_hit));
        chk("miss_pulse", 32'(miss_pulse), 32'(m_miss));
    end

    task automatic press(input logic [N-1:0] m);
        buttons = m;
        @(negedge clk);
        buttons = '0;
    endtask

    task automatic wait_state(input int s, input int budget);
        int n = 0;
        while (state !== 2'(s) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_state", 32'(state), 32'(s));
    endtask

    task automatic do_hit(input int exp_score);
        wait_state(2, 200);
        press(N'(1 << m_sel));
        chk("hit_pulse_lit", 32'(hit_pulse), 1);
        chk("hit_score_lit", 32'(score), 32'(exp_score));
        chk("hit_mole_lit", 32'(mole), 0);
        chk("hit_state_lit", 32'(state), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_mole", 32'(mole), 0);
        chk("rst_score", 32'(score), 0);
        chk("rst_lives", 32'(lives), 3);
        chk("rst_state", 32'(state), 0);
        @(negedge clk);

        press(4'b0001);
        chk("start_state", 32'(state), 1);
        chk("start_score", 32'(score), 0);
        chk("start_lives", 32'(lives), 3);

        do_hit(1);
        do_hit(2);

        wait_state(2, 200);
        n = 0;
        while (state === 2'd2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("window_6_ticks", 32'(n), 24);
        chk("timeout_miss", 32'(miss_pulse), 1);
        chk("timeout_lives", 32'(lives), 2);

        wait_state(2, 200);
        press(N'(1 << m_sel) | N'(1 << ((m_sel + 1) % N)));
        chk("both_miss", 32'(miss_pulse), 1);
        chk("both_no_hit", 32'(hit_pulse), 0);
        chk("both_lives", 32'(lives), 1);
        chk("both_score", 32'(score), 2);

        buttons = '1;
        wait_state(2, 200);
        wait_state(3, 200);
        chk("hold_score", 32'(score), 2);
        chk("end_lives", 32'(lives), 0);
        chk("end_mole_on", 32'(mole), 'hF);
        n = 0;
        while (mole === 4'hF && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("blink_on_len", 32'(n), 12);
        n = 0;
        while (mole === 4'h0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("blink_off_len", 32'(n), 12);
        buttons = '0;
        @(negedge clk);
        press(4'b0010);
        chk("idle_state", 32'(state), 0);
        chk("idle_score", 32'(score), 2);
        chk("idle_mole", 32'(mole), 0);
        press(4'b0001);
        chk("restart_score", 32'(score), 0);
        chk("restart_lives", 32'(lives), 3);

        wait_state(2, 200);
        press(N'(1 << ((m_sel + 2) % N)));
        chk("wrong_miss", 32'(miss_pulse), 1);
        chk("wrong_lives", 32'(lives), 2);
        chk("wrong_score", 32'(score), 0);

        do_hit(1);
        do_hit(2);
        do_hit(3);
        do_hit(3);

        wait_state(2, 200);
        #2 rst_n = 1'b0;
        #1;
        chk("async_mole", 32'(mole), 0);
        chk("async_state", 32'(state), 0);
        chk("async_score", 32'(score), 0);
        chk("async_lives", 32'(lives), 3);
        chk("async_hit", 32'(hit_pulse), 0);
        chk("async_miss", 32'(miss_pulse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/whack_a_mole_multi.md
Name: whack_a_mole_multi

Overview:
Parametrised N-hole successor to the single-mole game controller. A 16-bit LFSR picks which mole lights and how long to wait before it does. The hit window shrinks as the score rises, and pressing the wrong button costs a life. It sits between the per-button debouncers and the LED/seven-segment display drivers.

Parameters:
N_MOLES, 4, number of holes/buttons/LEDs (2..16)
TICK_DIV, 100000, clk cycles per game tick (1 ms at 100 MHz)
WAIT_MIN, 500, minimum ticks between moles
WAIT_SPAN, 1024, random extra wait range in ticks; power of 2
HIT_INIT, 1000, initial hit window in ticks
HIT_MIN, 300, floor of the hit window
HIT_STEP, 50, window reduction per speed-up
STEP_EVERY, 4, hits between speed-ups
LIVES_INIT, 3, lives at game start
SCORE_W, 8, score width; saturates at all-ones
LIVES_W, 4, lives width
BLINK_TICKS, 250, END-state LED toggle period in ticks
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted at 0)
buttons  in  N_MOLES  debounced, synchronous button levels
mole  out  N_MOLES  mole LEDs
score  out  SCORE_W  current/last score
lives  out  LIVES_W  remaining lives
state  out  2  IDLE=0, WAIT=1, UP=2, END=3
hit_pulse  out  1  one-cycle pulse on a valid hit
miss_pulse  out  1  one-cycle pulse on each life lost

Behaviour:
- Reset values: mole=0, score=0, lives=LIVES_INIT, state=IDLE, pulses=0. Internally: LFSR=LFSR_SEED, all timers=0, btn_prev=0, window=HIT_INIT.
- Edge detect: press[i] = buttons[i] & ~btn_prev[i]. btn_prev is registered every cycle; held buttons never re-trigger.
- The tick counter counts 0..TICK_DIV-1 and free-runs outside IDLE. tick is high for one cycle at wrap. All game timers decrement only on tick.
- The LFSR is a 16-bit Fibonacci LFSR with taps 16,14,13,11. It advances every clk in all states, so player timing adds entropy.
- Draw = the current LFSR value. delay = WAIT_MIN + (lfsr & (WAIT_SPAN-1)); idx = lfsr[7:0] % N_MOLES.
- IDLE:
  - mole=0; score and lives hold the last values.
  - Any press -> WAIT. On that transition: score=0, lives=LIVES_INIT, window=HIT_INIT, hit_cnt=0, wait_timer=delay, tick counter cleared.
- WAIT:
  - mole=0; presses are ignored.
  - On a tick with wait_timer==1 -> UP. On that transition: sel=idx, mole=one-hot(sel), hit_timer=window.
- UP (events are evaluated in priority order):
  1. A press on any non-selected button in the cycle -> miss. This applies even if the selected button is pressed in the same cycle.
  2. A press on the selected button -> hit. Hit beats a tick that would expire the window in the same cycle.
  3. A tick with hit_timer==1 -> miss (timeout).
- Hit: hit_pulse=1; score+1, saturating at 2^SCORE_W-1; hit_cnt+1; mole=0; wait_timer=delay; -> WAIT.
  - When hit_cnt reaches STEP_EVERY, hit_cnt=0 and window=max(window-HIT_STEP, HIT_MIN).
- Miss: miss_pulse=1; mole=0. If lives==1: lives=0 and -> END. Otherwise lives-1, wait_timer=delay, -> WAIT. lives never underflows.
- END:
  - All mole bits toggle together every BLINK_TICKS ticks, starting from all-on on entry.
  - score and lives hold.
  - Any press -> IDLE with mole=0.
- Reset assertion mid-game forces reset values immediately, independent of clk. There is no partial-state retention.
- Latency: press to hit_pulse/score update is 1 clk after the press edge is seen. Outputs are registered.

Decomposition:
- Package whack_pkg: state encoding constants (ST_IDLE, ST_WAIT, ST_UP, ST_END), LFSR width, and the tap mask.
- One sub-module, lfsr16. Ports: clk, reset, en, seed param, q[15:0]. It is reused by future game blocks.
- The tick divider stays inline.

Test Plan (TICK_DIV=4, WAIT_MIN=2, WAIT_SPAN=4, HIT_INIT=8, HIT_MIN=4, HIT_STEP=2, STEP_EVERY=2, N_MOLES=4):
- Reset low for 3 clk, then release -> mole=0, score=0, lives=3, state=0; press button 0 -> state=1 next clk, score=0, lives=3.
- In UP, press the selected button before the window ends -> hit_pulse for 1 clk, score=1, mole=0, state=1. After 2 hits, the next UP window lasts exactly 6 ticks (24 clk).
- In UP, press a non-selected button, alone and together with the selected one -> miss_pulse, lives 3->2, score unchanged, state=1.
- Hold the selected button through the entire UP, with its rising edge before UP -> no hit; timeout at 8 ticks -> miss_pulse, lives-1.
- Three consecutive timeouts -> lives 3,2,1,0; state=3; mole toggles 0xF/0x0 every BLINK_TICKS ticks; press -> state=0 with score held; next press -> score=0, lives=3.
- Score saturation with SCORE_W=2: 4 hits -> score stays 3. Assert reset during UP -> outputs return to reset values with no clk edge.
